// File: rtl/scan_sequencer_16_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : scan_pkg
//  Description: Shared state encodings and sizes for the 16-channel scan
//               sequencer.
//  Revision   : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int SEL_W  = 4;
    localparam int NUM_CH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_sequencer_16_if.sv
`default_nettype none
// ============================================================================
//  Module     : scan_sequencer_16_if
//  Description: Control/status bundle between a scan controller (master) and
//               the scan sequencer (slave). The onehot vector exists only
//               when SCAN_ONEHOT_EN is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
interface scan_sequencer_16_if #(
    parameter int DWELL_W = 8
);
    import scan_pkg::*;

    logic               start;
    logic               stop;
    logic               continuous;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   first_ch;
    logic [SEL_W-1:0]   last_ch;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               busy;
    logic               wrap;
    logic               done;
`ifdef SCAN_ONEHOT_EN
    logic [NUM_CH-1:0]  onehot;
`endif

    modport master (
        output start, stop, continuous, dwell, first_ch, last_ch,
`ifdef SCAN_ONEHOT_EN
        input  onehot,
`endif
        input  sel, sel_valid, busy, wrap, done
    );

    modport slave (
        input  start, stop, continuous, dwell, first_ch, last_ch,
`ifdef SCAN_ONEHOT_EN
        output onehot,
`endif
        output sel, sel_valid, busy, wrap, done
    );

endinterface : scan_sequencer_16_if
`default_nettype wire

// File: rtl/scan_sequencer_16_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module     : dwell_counter
//  Description: Loadable down-counter that saturates at zero and flags it.
//  Revision   : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         load,
    input  wire logic [W-1:0] load_val,
    output logic              zero
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule : dwell_counter
`default_nettype wire

// File: rtl/scan_sequencer_16.sv
`default_nettype none
// ============================================================================
//  Module     : scan_sequencer_16
//  Description: Programmable channel scanner producing the 4-bit select code
//               for a 4:16 decoder, with per-channel dwell, single/continuous
//               sweeps and wrap/done pulses.
//               Define SCAN_ONEHOT_EN to add an internal one-hot decode.
//  Revision   : 1.0 - initial release
// ============================================================================
module scan_sequencer_16
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    scan_sequencer_16_if.slave bus
);

    state_t             state;
    logic [SEL_W-1:0]   cur_sel;
    logic               sel_valid_q;
    logic               busy_q;
    logic               done_q;

    logic               cfg_cont;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [SEL_W-1:0]   cfg_first;
    logic [SEL_W-1:0]   cfg_last;

    logic               cnt_zero;
    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_load_val;
    logic               start_ok;
    logic               hold_end;
    logic               last_hold;

    assign start_ok  = (state == ST_IDLE) && bus.start && !bus.stop;
    // Final clock of the current channel's hold time while running.
    assign hold_end  = (state == ST_RUN) && !bus.stop && cnt_zero;
    // Final hold clock of the last channel in the sweep.
    assign last_hold = hold_end && (cur_sel == cfg_last);

    // Reload at start, and at every channel advance except the end of a
    // single sweep.
    assign cnt_load     = start_ok || (hold_end && !(last_hold && !cfg_cont));
    assign cnt_load_val = (state == ST_IDLE) ? bus.dwell : cfg_dwell;

    dwell_counter #(
        .W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // Scan FSM with registered select, valid, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_sel     <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_cont    <= 1'b0;
            cfg_dwell   <= '0;
            cfg_first   <= '0;
            cfg_last    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cfg_cont    <= bus.continuous;
                        cfg_dwell   <= bus.dwell;
                        cfg_first   <= bus.first_ch;
                        cfg_last    <= bus.last_ch;
                        cur_sel     <= bus.first_ch;
                        sel_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        sel_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (cnt_zero) begin
                        if (cur_sel != cfg_last) begin
                            cur_sel <= cur_sel + 4'd1;
                        end else if (cfg_cont) begin
                            cur_sel <= cfg_first;
                        end else begin
                            sel_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel       = cur_sel;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wrap      = last_hold;

`ifdef SCAN_ONEHOT_EN
    assign bus.onehot = sel_valid_q ? ({{(NUM_CH-1){1'b0}}, 1'b1} << cur_sel) : '0;
`endif

endmodule : scan_sequencer_16
`default_nettype wire
